// File: rtl/rv32_mod_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mod_mem_responder
// Brief    : Word RAM on the req/ack/err bus; byte-enabled writes, wait states.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_mod_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          SIZE_WORDS  = 1024,
    parameter int          WAIT_STATES = 1,
    parameter bit          READ_ONLY   = 1'b0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic        ack,
    output logic        err,
    output logic [31:0] data_o,
    output logic        busy
);

    localparam int          c_IDX_W    = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
    localparam logic [32:0] c_BASE     = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_LIMIT    = c_BASE + 33'(4 * SIZE_WORDS);
    localparam logic [3:0]  c_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_cnt;
    logic               r_wr;
    logic [3:0]         r_be;
    logic [c_IDX_W-1:0] r_idx;
    logic [31:0]        r_wdata;
    logic               r_fault;
    logic               r_ack;
    logic               r_err;
    logic [31:0]        r_data_o;
    logic [31:0]        r_mem [SIZE_WORDS];

    logic               w_in_fault;
    logic [31:0]        w_off;
    logic [c_IDX_W-1:0] w_in_idx;
    logic               w_accept;
    logic               w_commit;
    logic               w_live;
    logic               w_c_wr;
    logic [3:0]         w_c_be;
    logic [c_IDX_W-1:0] w_c_idx;
    logic [31:0]        w_c_wdata;
    logic               w_c_fault;

    // 33-bit range compare so addresses near 2^32 cannot wrap into range
    assign w_in_fault = ({1'b0, addr} < c_BASE) || ({1'b0, addr} >= c_LIMIT) ||
                        (be == 4'b0000) || (wr && READ_ONLY);
    assign w_off      = addr - BASE_ADDR;
    assign w_in_idx   = c_IDX_W'(w_off >> 2);

    // With zero wait states the commit edge is the accept edge, so use live inputs
    assign w_live    = (r_state == c_S_IDLE);
    assign w_c_wr    = w_live ? wr         : r_wr;
    assign w_c_be    = w_live ? be         : r_be;
    assign w_c_idx   = w_live ? w_in_idx   : r_idx;
    assign w_c_wdata = w_live ? data_i     : r_wdata;
    assign w_c_fault = w_live ? w_in_fault : r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (req) begin
                    w_next_state = (WAIT_STATES == 0) ? c_S_RESP : c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = c_S_RESP;
                end
            end
            c_S_RESP: w_next_state = c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != c_S_IDLE);
        w_accept = (r_state == c_S_IDLE) && req;
        w_commit = ((r_state == c_S_IDLE) && req && (WAIT_STATES == 0)) ||
                   ((r_state == c_S_WAIT) && (r_cnt == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_be    <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= c_CNT_INIT;
            r_wr    <= wr;
            r_be    <= be;
            r_idx   <= w_in_idx;
            r_wdata <= data_i;
            r_fault <= w_in_fault;
        end else if ((r_state == c_S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_data_o <= 32'd0;
        end else begin
            r_ack <= w_commit && !w_c_fault;
            r_err <= w_commit && w_c_fault;
            if (w_commit) begin
                if (w_c_fault) begin
                    r_data_o <= 32'd0;
                end else if (!w_c_wr) begin
                    r_data_o <= r_mem[w_c_idx];
                end
            end
        end
    end

    // Array has no reset: contents survive a bus reset
    always_ff @(posedge clk) begin
        if (!reset && w_commit && w_c_wr && !w_c_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_c_be[i]) begin
                    r_mem[w_c_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ack    = r_ack;
    assign err    = r_err;
    assign data_o = r_data_o;

endmodule
`default_nettype wire

// File: tb/tb_rv32_mod_mem_responder.sv
`default_nettype none
// Bench for rv32_mod_mem_responder: table-driven scoreboard on a 1-wait-state
// instance plus hand sequences for zero/three wait states and read-only mode.
module tb_rv32_mod_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst = 1'b1;
    logic rst2 = 1'b1;

    logic req0 = 0, wr0 = 0; logic [3:0] be0 = 0; logic [31:0] addr0 = 0, din0 = 0;
    logic ack0, err0, busy0; logic [31:0] dout0;
    logic req1 = 0, wr1 = 0; logic [3:0] be1 = 0; logic [31:0] addr1 = 0, din1 = 0;
    logic ack1, err1, busy1; logic [31:0] dout1;
    logic req2 = 0, wr2 = 0; logic [3:0] be2 = 0; logic [31:0] addr2 = 0, din2 = 0;
    logic ack2, err2, busy2; logic [31:0] dout2;
    logic req3 = 0, wr3 = 0; logic [3:0] be3 = 0; logic [31:0] addr3 = 0, din3 = 0;
    logic ack3, err3, busy3; logic [31:0] dout3;

    rv32_mod_mem_responder #(.WAIT_STATES(1)) u0 (
        .clk(clk), .reset(rst), .req(req0), .wr(wr0), .be(be0), .addr(addr0),
        .data_i(din0), .ack(ack0), .err(err0), .data_o(dout0), .busy(busy0));
    rv32_mod_mem_responder #(.WAIT_STATES(0)) u1 (
        .clk(clk), .reset(rst), .req(req1), .wr(wr1), .be(be1), .addr(addr1),
        .data_i(din1), .ack(ack1), .err(err1), .data_o(dout1), .busy(busy1));
    rv32_mod_mem_responder #(.WAIT_STATES(3)) u2 (
        .clk(clk), .reset(rst2), .req(req2), .wr(wr2), .be(be2), .addr(addr2),
        .data_i(din2), .ack(ack2), .err(err2), .data_o(dout2), .busy(busy2));
    rv32_mod_mem_responder #(.WAIT_STATES(1), .READ_ONLY(1'b1)) u3 (
        .clk(clk), .reset(rst), .req(req3), .wr(wr3), .be(be3), .addr(addr3),
        .data_i(din3), .ack(ack3), .err(err3), .data_o(dout3), .busy(busy3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic        exp_err;
        logic        chk_data;
        logic [31:0] exp_data;
    } resp_t;

    resp_t sb[$];
    logic  prev0 = 1'b0;

    // Scoreboard: every u0 response pops the record pushed when it was issued
    always @(negedge clk) begin
        if (!rst && (ack0 || err0)) begin
            check("u0_no_back2back", prev0, 0);
            check("u0_ack_and_err", ack0 & err0, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u0_unexpected_resp: got ack=%b err=%b expected none", ack0, err0);
            end else begin
                resp_t r;
                r = sb.pop_front();
                check("u0_err", err0, r.exp_err);
                check("u0_ack", ack0, !r.exp_err);
                if (r.chk_data) check("u0_data", dout0, r.exp_data);
            end
        end
        prev0 = ack0 | err0;
    end

    task automatic txn0(input vec_t v, input int n);
        resp_t r;
        int    lat;
        bit    seen;
        @(negedge clk);
        req0 = 1; wr0 = v.wr; be0 = v.be; addr0 = v.addr; din0 = v.wdata;
        r.exp_err  = v.exp_err;
        r.chk_data = !v.wr || v.exp_err;
        r.exp_data = v.exp_data;
        sb.push_back(r);
        @(posedge clk);
        #1;
        req0 = 0; wr0 = 0; be0 = 0; addr0 = 0; din0 = 0;
        seen = 0;
        lat  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            check($sformatf("u0_busy_v%0d_c%0d", n, k), busy0, 1);
            if (ack0 || err0) begin
                seen = 1;
                lat  = k;
            end
        end
        if (!seen) begin
            void'(sb.pop_front());
            $display("FAIL u0_timeout_v%0d: got no response expected one", n);
            errors++;
        end
        check($sformatf("u0_latency_v%0d", n), lat, 2);
    endtask

    task automatic txn2(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int rst_k, input logic exp_resp, input logic [31:0] exp_d,
                        input string nm);
        @(negedge clk);
        req2 = 1; wr2 = w; be2 = 4'hF; addr2 = a; din2 = d;
        @(posedge clk);
        #1;
        req2 = 0; wr2 = 0; be2 = 0; addr2 = 0; din2 = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("%s_ack_c%0d", nm, k), ack2, (exp_resp && k == 4) ? 32'd1 : 32'd0);
            check($sformatf("%s_err_c%0d", nm, k), err2, 0);
            check($sformatf("%s_busy_c%0d", nm, k), busy2,
                  ((rst_k == 0) ? (k <= 4) : (k <= rst_k)) ? 32'd1 : 32'd0);
            if (exp_resp && k == 4 && !w) check({nm, "_data"}, dout2, exp_d);
            if (rst_k != 0 && k == rst_k) rst2 = 1;
            if (rst_k != 0 && k == rst_k + 1) rst2 = 0;
        end
    endtask

    task automatic txn3(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic exp_err, input string nm);
        @(negedge clk);
        req3 = 1; wr3 = w; be3 = b; addr3 = a; din3 = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        req3 = 0; wr3 = 0; be3 = 0; addr3 = 0; din3 = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("%s_ack_c%0d", nm, k), ack3, (k == 2 && !exp_err) ? 32'd1 : 32'd0);
            check($sformatf("%s_err_c%0d", nm, k), err3, (k == 2 && exp_err) ? 32'd1 : 32'd0);
            if (k == 2 && exp_err) check({nm, "_data"}, dout3, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[19];
        vecs[0]  = '{1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'hF, 32'h8000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 4'h5, 32'h8000_0010, 32'h1122_3344, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'hF, 32'h8000_0010, 32'h0,         1'b0, 32'hDE22_BE44};
        vecs[4]  = '{1'b0, 4'hF, 32'h8000_1000, 32'h0,         1'b1, 32'h0};
        vecs[5]  = '{1'b0, 4'hF, 32'h7FFF_FFFC, 32'h0,         1'b1, 32'h0};
        vecs[6]  = '{1'b0, 4'hF, 32'h8000_0010, 32'h0,         1'b0, 32'hDE22_BE44};
        vecs[7]  = '{1'b1, 4'h0, 32'h8000_0010, 32'h5555_5555, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 4'h1, 32'h8000_0010, 32'h0,         1'b0, 32'hDE22_BE44};
        vecs[9]  = '{1'b1, 4'hF, 32'h8000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 4'hF, 32'h8000_0FFF, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[11] = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
        vecs[12] = '{1'b1, 4'hF, 32'h7FFF_FFFC, 32'h9999_9999, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 4'hF, 32'h8000_0000, 32'h0102_0304, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 4'h8, 32'h8000_0000, 32'hAB00_0000, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 4'hF, 32'h8000_0000, 32'h0,         1'b0, 32'hAB02_0304};
        vecs[16] = '{1'b0, 4'hF, 32'h8000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[17] = '{1'b1, 4'hF, 32'h8000_1000, 32'h7777_7777, 1'b1, 32'h0};
        vecs[18] = '{1'b0, 4'hF, 32'h8000_0000, 32'h0,         1'b0, 32'hAB02_0304};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        rst2 = 0;
        @(negedge clk);
        check("rst_u0_ack", ack0, 0);
        check("rst_u0_err", err0, 0);
        check("rst_u0_busy", busy0, 0);
        check("rst_u0_data", dout0, 0);
        check("rst_u2_busy", busy2, 0);
        check("rst_u2_data", dout2, 0);

        for (int i = 0; i < 19; i++) txn0(vecs[i], i);

        // Zero wait states: single write, then req held high across three reads
        @(negedge clk);
        req1 = 1; wr1 = 1; be1 = 4'hF; addr1 = 32'h8000_0000; din1 = 32'h1234_5678;
        @(posedge clk);
        #1;
        req1 = 0; wr1 = 0;
        @(negedge clk);
        check("u1_wr_ack_c1", ack1, 1);
        @(negedge clk);
        req1 = 1; wr1 = 0; be1 = 4'hF; addr1 = 32'h8000_0000;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            if (k == 6) begin
                #1;
                req1 = 0;
            end
            @(negedge clk);
            check($sformatf("u1_ack_c%0d", k), ack1, (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("u1_err_c%0d", k), err1, 0);
            if (k % 2 == 1) check($sformatf("u1_data_c%0d", k), dout1, 32'h1234_5678);
        end

        // Three wait states with req dropped after acceptance, then reset abort
        txn2(1'b1, 32'h8000_0020, 32'hA5A5_A5A5, 0, 1'b1, 32'h0, "u2_wr");
        txn2(1'b0, 32'h8000_0020, 32'h0, 0, 1'b1, 32'hA5A5_A5A5, "u2_rd");
        txn2(1'b1, 32'h8000_0020, 32'h5A5A_5A5A, 2, 1'b0, 32'h0, "u2_rstwr");
        txn2(1'b0, 32'h8000_0020, 32'h0, 0, 1'b1, 32'hA5A5_A5A5, "u2_rd2");

        // Read-only instance
        txn3(1'b1, 4'hF, 32'h8000_0000, 1'b1, "u3_wr");
        txn3(1'b0, 4'hF, 32'h8000_0000, 1'b0, "u3_rd");
        txn3(1'b0, 4'h0, 32'h8000_0000, 1'b1, "u3_be0");
        txn3(1'b1, 4'hF, 32'h8000_1000, 1'b1, "u3_oor");

        repeat (3) @(negedge clk);
        check("u0_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
